aes_key_expand_wr: RTL and testbench
====================================

Name: aes_key_expand_wr

Overview:
- Upstream producer for the 128-bit x 16 round-key RAM.
- Takes a 128-bit AES-128 cipher key and generates the 11 round keys (rounds 0..10) per FIPS-197 key expansion, one round per clock.
- Writes each round key into the RAM through that RAM's write port (address, data, wren), so the cipher datapath can read keys out by round number.

Parameters:
- A_WIDTH, 4, RAM address width; must be at least 4.
- BASE_ADDR, 0, RAM address of round key 0; BASE_ADDR + 10 must be < 2^A_WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request expansion; sampled only in IDLE.
- key_in  input  128  cipher key, byte 0 in [127:120]; captured on the accepted start cycle only.
- ram_addr  output  A_WIDTH  RAM write address.
- ram_data  output  128  round key being written.
- ram_wren  output  1  RAM write enable; one write per asserted cycle.
- busy  output  1  high from the cycle after start acceptance until done.
- done  output  1  single-cycle pulse after the last write.
- round_cnt  output  4  current round index being written (0..10).

Behaviour:
- Reset (asynchronous, rst_n low):
  - state=IDLE.
  - ram_wren=0, ram_addr=0, ram_data=0, busy=0, done=0, round_cnt=0.
  - Key register and rcon are cleared.
- States:
  - IDLE -> WRITE on start=1 (edge T). key_in is latched into key_reg; rcon=0x01; round_cnt=0.
  - WRITE lasts exactly 11 cycles (T+1..T+11). Each cycle, all registered outputs hold:
    - ram_wren=1
    - ram_addr=BASE_ADDR+round_cnt
    - ram_data=key_reg
  - At each edge in WRITE, key_reg <= next_round_key(key_reg, rcon), rcon <= xtime(rcon), round_cnt++.
  - WRITE -> DONE when round_cnt==10 at the edge.
  - DONE lasts 1 cycle (T+12): done=1, ram_wren=0, busy=0. Then -> IDLE.
- next_round_key:
  - temp = SubWord(RotWord(w3)) ^ {rcon,24'h0}.
  - w0'=w0^temp, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
  - w0 is key_reg[127:96].
- rcon sequence: 01,02,04,08,10,20,40,80,1B,36. xtime is GF(2^8) doubling, reducing by 0x1B on MSB carry.
- S-box:
  - Four parallel instances of the FIPS-197 forward S-box, as a combinational function (256-entry case).
  - No extra pipeline stage; the critical path is S-box plus 4-deep XOR chain.
- busy is 1 on cycles T+1..T+11. done and ram_wren are never high in the same cycle.
- start while busy or in DONE is ignored; no queuing. start held high continuously restarts from IDLE on the cycle after DONE.
- key_in changes after the accepted start cycle have no effect.
- rst_n asserted mid-WRITE:
  - ram_wren drops immediately, without waiting for the clock.
  - No done pulse.
  - RAM contents already written are left as-is; the partial set is invalid.
- Latency: first write on cycle T+1, last write on T+11, done on T+12.

Optional Feature:
- Macro: AES_KEYEXP_REVERSE_ORDER_EN.
- Defined: round r is written to address BASE_ADDR+(10-r), so the decryption datapath reads round keys in ascending address order. Write sequence in time is unchanged (round 0 first). round_cnt still reports r.
- Undefined: round r is written to address BASE_ADDR+r.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start pulse:
  - T+1: ram_addr=0, ram_data=2b7e1516...4f3c.
  - T+2: ram_addr=1, ram_data=a0fafe1788542cb123a339392a6c7605.
  - T+11: ram_addr=10, ram_data=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - T+12: done=1.
- Same key with AES_KEYEXP_REVERSE_ORDER_EN defined:
  - T+1 writes address 10 with the key.
  - T+11 writes address 0 with d014f9a8c9ee2589e13f0cc8b6630ca6.
- All-zero key: round 1 = 62636363626363636263636362636363; round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- start re-pulsed at T+5 with a different key_in -> ignored. Sequence and round-10 value match the first key; exactly 11 wren cycles.
- rst_n low at T+6 (asynchronous, between edges) -> ram_wren, busy and ram_data go 0 immediately and no done follows. A new start after release produces a full 11-write sequence from address 0.
- Back-to-back: start held high -> done at T+12, next write burst begins T+14. ram_wren stays 0 on T+12 and T+13.

Source files
------------

// File: rtl/aes_key_expand_wr.sv
// AES-128 key expansion feeding the 128-bit x 16 round-key RAM write port.
// One round key per clock: round 0 (the cipher key) through round 10.
// Optional build macro AES_KEYEXP_REVERSE_ORDER_EN: round r lands at
// BASE_ADDR+(10-r) instead of BASE_ADDR+r (write order in time unchanged).

// Forward AES S-box, one byte lane.
module aes_sbox_lane (
    input  logic [7:0] a,
    output logic [7:0] s
);
    // Full 256-entry lookup, purely combinational.
    always_comb begin
        s = 8'h00;
        case (a)
            8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
            8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
            8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
            8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
            8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
            8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
            8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
            8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
            8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
            8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
            8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
            8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
            8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
            8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
            8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
            8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
            8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
            8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
            8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
            8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
            8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
            8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
            8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
            8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
            8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
            8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
            8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
            8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
            8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
            8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
            8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
            8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
            default: s = 8'h00;
        endcase
    end
endmodule

module aes_key_expand_wr #(
    parameter int A_WIDTH   = 4,
    parameter int BASE_ADDR = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [127:0]       key_in,
    output logic [A_WIDTH-1:0] ram_addr,
    output logic [127:0]       ram_data,
    output logic               ram_wren,
    output logic               busy,
    output logic               done,
    output logic [3:0]         round_cnt
);
    localparam int NUM_LANES = 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [A_WIDTH-1:0] BASE = A_WIDTH'(BASE_ADDR);

    logic [1:0]   state;
    logic [127:0] key_reg;
    logic [7:0]   rcon;
    logic [3:0]   cnt_q;

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] nw0, nw1, nw2, nw3, temp;
    logic [NUM_LANES-1:0][7:0] sb_in, sb_out;
    logic [7:0]  rcon_nxt;
    logic        wr;
    logic [A_WIDTH-1:0] addr_off;

    assign w0 = key_reg[127:96];
    assign w1 = key_reg[95:64];
    assign w2 = key_reg[63:32];
    assign w3 = key_reg[31:0];

    // RotWord: rotate w3 left by one byte before substitution.
    assign sb_in = {w3[23:0], w3[31:24]};

    genvar l;
    generate
        for (l = 0; l < NUM_LANES; l++) begin : g_sbox
            aes_sbox_lane u_sbox (.a(sb_in[l]), .s(sb_out[l]));
        end
    endgenerate

    assign temp = sb_out ^ {rcon, 24'h0};
    assign nw0  = w0 ^ temp;
    assign nw1  = w1 ^ nw0;
    assign nw2  = w2 ^ nw1;
    assign nw3  = w3 ^ nw2;

    // GF(2^8) doubling for the next round constant.
    assign rcon_nxt = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);

    // Control FSM and key schedule state; one round key per WRITE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            key_reg <= '0;
            rcon    <= '0;
            cnt_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        key_reg <= key_in;
                        rcon    <= 8'h01;
                        cnt_q   <= '0;
                        state   <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    // Round 10 is the last write; the counter stays at 10 so
                    // round_cnt never reports an out-of-range index.
                    if (cnt_q == 4'd10) begin
                        state <= S_DONE;
                    end else begin
                        key_reg <= {nw0, nw1, nw2, nw3};
                        rcon    <= rcon_nxt;
                        cnt_q   <= cnt_q + 4'd1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef AES_KEYEXP_REVERSE_ORDER_EN
    assign addr_off = A_WIDTH'(4'd10 - cnt_q);
`else
    assign addr_off = A_WIDTH'(cnt_q);
`endif

    // Outputs decode straight from the state registers, so an asynchronous
    // reset drops the write strobe without waiting for a clock edge.
    assign wr        = (state == S_WRITE);
    assign ram_wren  = wr;
    assign busy      = wr;
    assign done      = (state == S_DONE);
    assign ram_data  = wr ? key_reg : '0;
    assign ram_addr  = wr ? (BASE + addr_off) : '0;
    assign round_cnt = cnt_q;
endmodule

// File: tb/tb_aes_key_expand_wr.sv
// Directed bench for aes_key_expand_wr using FIPS-197 and all-zero key vectors.
module tb_aes_key_expand_wr;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] key_in;
    logic [3:0]   ram_addr;
    logic [127:0] ram_data;
    logic         ram_wren;
    logic         busy;
    logic         done;
    logic [3:0]   round_cnt;

    int errors = 0;
    int checks = 0;
    int wren_cnt = 0;

    localparam logic [127:0] K_FIPS   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K_FIPS1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K_FIPS10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] K_ZERO1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] K_ZERO10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    localparam logic [127:0] K_OTHER  = 128'h000102030405060708090a0b0c0d0e0f;

    aes_key_expand_wr #(.A_WIDTH(4), .BASE_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren),
        .busy(busy), .done(done), .round_cnt(round_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (ram_wren === 1'b1) wren_cnt <= wren_cnt + 1;

    function automatic logic [3:0] exp_addr(input int r);
`ifdef AES_KEYEXP_REVERSE_ORDER_EN
        return 4'(10 - r);
`else
        return 4'(r);
`endif
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs one expansion from IDLE; optionally re-pulses start mid-burst.
    task automatic run_key(input string nm, input logic [127:0] k,
                           input logic [127:0] e1, input logic [127:0] e10,
                           input bit repulse);
        int c0;
        @(negedge clk);
        c0 = wren_cnt;
        start = 1'b1; key_in = k;
        @(negedge clk);                         // T+1
        start = 1'b0; key_in = ~k;
        chk({nm, " r0 wren"}, 128'(ram_wren), 128'(1'b1));
        chk({nm, " r0 busy"}, 128'(busy), 128'(1'b1));
        chk({nm, " r0 addr"}, 128'(ram_addr), 128'(exp_addr(0)));
        chk({nm, " r0 data"}, ram_data, k);
        chk({nm, " r0 cnt"}, 128'(round_cnt), 128'(0));
        for (int r = 1; r <= 10; r++) begin
            if (repulse && r == 4) begin start = 1'b1; key_in = K_OTHER; end
            @(negedge clk);                     // T+1+r
            start = 1'b0;
            chk($sformatf("%s r%0d addr", nm, r), 128'(ram_addr), 128'(exp_addr(r)));
            chk($sformatf("%s r%0d cnt", nm, r), 128'(round_cnt), 128'(r));
            chk($sformatf("%s r%0d wren", nm, r), 128'({ram_wren, done}), 128'(2'b10));
            if (r == 1)  chk({nm, " r1 data"}, ram_data, e1);
            if (r == 10) chk({nm, " r10 data"}, ram_data, e10);
        end
        @(negedge clk);                         // T+12
        chk({nm, " done"}, 128'({done, ram_wren, busy}), 128'(3'b100));
        @(negedge clk);                         // T+13
        chk({nm, " idle"}, 128'({done, ram_wren, busy}), 128'(3'b000));
        chk({nm, " wren count"}, 128'(wren_cnt - c0), 128'(11));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; key_in = '0;
        #2;
        chk("reset wren", 128'(ram_wren), 128'(0));
        chk("reset flags", 128'({busy, done}), 128'(0));
        chk("reset addr", 128'(ram_addr), 128'(0));
        chk("reset data", ram_data, 128'(0));
        chk("reset cnt", 128'(round_cnt), 128'(0));
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        run_key("fips", K_FIPS, K_FIPS1, K_FIPS10, 1'b0);
        run_key("zero", 128'(0), K_ZERO1, K_ZERO10, 1'b0);
        run_key("repulse", K_FIPS, K_FIPS1, K_FIPS10, 1'b1);

        // Asynchronous reset in the middle of a burst.
        @(negedge clk);
        start = 1'b1; key_in = K_FIPS;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);              // T+6
        chk("mid wren before rst", 128'(ram_wren), 128'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("mid rst wren", 128'(ram_wren), 128'(0));
        chk("mid rst busy", 128'(busy), 128'(0));
        chk("mid rst data", ram_data, 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("post rst quiet %0d", i), 128'({done, ram_wren}), 128'(0));
        end
        run_key("after rst", K_FIPS, K_FIPS1, K_FIPS10, 1'b0);

        // start held high: second burst begins on T+14.
        @(negedge clk);
        start = 1'b1; key_in = K_FIPS;
        @(negedge clk);                         // T+1
        chk("b2b first wren", 128'(ram_wren), 128'(1));
        repeat (10) @(negedge clk);             // T+11
        chk("b2b last data", ram_data, K_FIPS10);
        @(negedge clk);                         // T+12
        chk("b2b T12", 128'({done, ram_wren}), 128'(2'b10));
        @(negedge clk);                         // T+13
        chk("b2b T13", 128'({done, ram_wren}), 128'(2'b00));
        @(negedge clk);                         // T+14
        start = 1'b0;
        chk("b2b T14 wren", 128'(ram_wren), 128'(1));
        chk("b2b T14 addr", 128'(ram_addr), 128'(exp_addr(0)));
        chk("b2b T14 data", ram_data, K_FIPS);
        repeat (12) @(negedge clk);
        chk("b2b settle", 128'({busy, ram_wren}), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
